// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared definitions for the memory-stage load/store unit.
//   - funct3 encodings for access size and sign
//   - FSM state enum
//   - access-size decode helper (unlisted funct3 codes decode as word)
package mem_access_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_t;

  // Access width from funct3; 011/110/111 fall through to word.
  function automatic size_t f3_size(input logic [2:0] f3);
    size_t sz;
    case (f3)
      F3_B, F3_BU: sz = SZ_B;
      F3_H, F3_HU: sz = SZ_H;
      default:     sz = SZ_W;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/load_formatter.sv
// load_formatter: combinational lane select and extension of a read word.
// Ports:
//   mem_rdata  in  32  raw word returned by the bus
//   funct3     in  3   access size/sign of the completed load
//   addr_lo    in  2   byte offset of the load within the word
//   load_data  out 32  selected byte/half, sign- or zero-extended; word passthrough
module load_formatter
  import mem_access_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  output logic [31:0] load_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Pick the addressed byte/half and extend according to funct3.
  always_comb begin
    byte_s    = mem_rdata[{addr_lo, 3'b000} +: 8];
    half_s    = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_data = mem_rdata;
    case (funct3)
      F3_B:    load_data = {{24{byte_s[7]}}, byte_s};
      F3_BU:   load_data = {24'h00_0000, byte_s};
      F3_H:    load_data = {{16{half_s[15]}}, half_s};
      F3_HU:   load_data = {16'h0000, half_s};
      default: load_data = mem_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage load/store unit with a single-outstanding
// req/ack data bus.
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   rd_en, wr_en       load/store request of the instruction in the memory stage
//   funct3, addr       access size/sign and byte address
//   wdata              right-aligned store data
//   mem_req/we/addr/wdata/wstrb  registered bus request, held until mem_ack
//   mem_ack, mem_rdata bus completion pulse and read word
//   stall              freeze upstream pipeline (combinational)
//   load_data/valid    registered formatted load result and its one-cycle valid
//   ld/st_misalign     misaligned access exceptions (combinational, IDLE only)
module mem_access_unit
  import mem_access_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        ld_misalign,
  output logic        st_misalign
);

  state_t      state_r;
  state_t      state_nx_s;
  size_t       size_s;
  logic        req_s;
  logic        store_s;
  logic        mis_s;
  logic [3:0]  strb_s;
  logic [31:0] lane_data_s;
  logic        issue_s;
  logic        load_done_s;
  logic [2:0]  funct3_r;
  logic [1:0]  addr_lo_r;
  logic [31:0] fmt_data_s;

  // A store wins when both enables are set.
  assign req_s       = rd_en | wr_en;
  assign store_s     = wr_en;
  assign size_s      = f3_size(funct3);
  assign issue_s     = (state_r == IDLE) && (state_nx_s == BUSY);
  assign load_done_s = (state_r == BUSY) && mem_ack && !mem_we;

  // Alignment check on the incoming address for the decoded access size.
  always_comb begin
    mis_s = 1'b0;
    case (size_s)
      SZ_H:    mis_s = addr[0];
      SZ_W:    mis_s = (addr[1:0] != 2'b00);
      default: mis_s = 1'b0;
    endcase
  end

  // Byte-lane strobes and lane-replicated store data.
  always_comb begin
    strb_s      = 4'b1111;
    lane_data_s = wdata;
    case (size_s)
      SZ_B: begin
        strb_s      = 4'b0001 << addr[1:0];
        lane_data_s = {4{wdata[7:0]}};
      end
      SZ_H: begin
        strb_s      = 4'b0011 << addr[1:0];
        lane_data_s = {2{wdata[15:0]}};
      end
      default: begin
        strb_s      = 4'b1111;
        lane_data_s = wdata;
      end
    endcase
  end

  // Next-state, stall and misalignment flags.
  always_comb begin
    state_nx_s  = state_r;
    stall       = 1'b0;
    ld_misalign = 1'b0;
    st_misalign = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          if (mis_s) begin
            // Misaligned: flag only, no bus access, stay in IDLE.
            ld_misalign = ~store_s;
            st_misalign = store_s;
            state_nx_s  = IDLE;
          end else begin
            stall      = 1'b1;
            state_nx_s = BUSY;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (mem_ack) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = BUSY;
        end
      end
      // The completed instruction is still presented here; ignore its enables.
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Bus request registers, latched access attributes and load result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'h0000_0000;
      mem_wdata  <= 32'h0000_0000;
      mem_wstrb  <= 4'b0000;
      funct3_r   <= 3'b000;
      addr_lo_r  <= 2'b00;
      load_data  <= 32'h0000_0000;
      load_valid <= 1'b0;
    end else begin
      mem_req    <= (state_nx_s == BUSY);
      load_valid <= load_done_s;
      if (issue_s) begin
        mem_we    <= store_s;
        mem_addr  <= {addr[31:2], 2'b00};
        mem_wdata <= lane_data_s;
        mem_wstrb <= store_s ? strb_s : 4'b0000;
        funct3_r  <= funct3;
        addr_lo_r <= addr[1:0];
      end
      if (load_done_s) begin
        load_data <= fmt_data_s;
      end
    end
  end

  load_formatter u_load_formatter (
    .mem_rdata (mem_rdata),
    .funct3    (funct3_r),
    .addr_lo   (addr_lo_r),
    .load_data (fmt_data_s)
  );

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized
// accesses checked against a behavioural model of the load/store rules.
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        rd_en;
  logic        wr_en;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        ld_misalign;
  logic        st_misalign;

  int          n_total;
  int          n_bad;
  logic [31:0] model_ld;

  mem_access_unit dut (
    .clk         (clk),
    .rst         (rst),
    .rd_en       (rd_en),
    .wr_en       (wr_en),
    .funct3      (funct3),
    .addr        (addr),
    .wdata       (wdata),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .stall       (stall),
    .load_data   (load_data),
    .load_valid  (load_valid),
    .ld_misalign (ld_misalign),
    .st_misalign (st_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One access from the memory stage; wt = extra cycles before the ack.
  task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rword, input int wt);
    logic        st;
    int          sz;
    logic        mis;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata;
    logic [31:0] e_ld;
    logic [31:0] v;
    int          stalls;
    st  = wr;
    sz  = (f3 == 3'd0 || f3 == 3'd4) ? 1 : ((f3 == 3'd1 || f3 == 3'd5) ? 2 : 4);
    mis = (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00);
    if (sz == 1) begin
      e_strb  = 4'((1 << a[1:0]));
      e_wdata = (wd & 32'h0000_00FF) * 32'h0101_0101;
    end else if (sz == 2) begin
      e_strb  = 4'((3 << a[1:0]));
      e_wdata = (wd & 32'h0000_FFFF) * 32'h0001_0001;
    end else begin
      e_strb  = 4'hF;
      e_wdata = wd;
    end
    if (!st) e_strb = 4'h0;
    v = rword >> (8 * a[1:0]);
    if (sz == 1) begin
      v = v & 32'h0000_00FF;
      if (f3 == 3'd0 && v >= 32'd128) v = v | 32'hFFFF_FF00;
    end else if (sz == 2) begin
      v = v & 32'h0000_FFFF;
      if (f3 == 3'd1 && v >= 32'd32768) v = v | 32'hFFFF_0000;
    end else begin
      v = rword;
    end
    e_ld = v;

    @(negedge clk);
    rd_en = rd; wr_en = wr; funct3 = f3; addr = a; wdata = wd;
    #1;
    chk("idle_req", {31'd0, mem_req}, 32'd0);
    chk("idle_lvalid", {31'd0, load_valid}, 32'd0);
    chk("held_ldata", load_data, model_ld);
    chk("idle_stall", {31'd0, stall}, {31'd0, !mis});
    chk("ld_mis", {31'd0, ld_misalign}, {31'd0, mis && !st});
    chk("st_mis", {31'd0, st_misalign}, {31'd0, mis && st});
    if (mis) begin
      @(posedge clk); #1;
      rd_en = 1'b0; wr_en = 1'b0;
      #1;
      chk("mis_noreq", {31'd0, mem_req}, 32'd0);
      chk("mis_flag_gone", {30'd0, ld_misalign, st_misalign}, 32'd0);
      return;
    end
    stalls = 1;
    for (int i = 0; i <= wt; i++) begin
      @(negedge clk); #1;
      chk("busy_req", {31'd0, mem_req}, 32'd1);
      chk("busy_we", {31'd0, mem_we}, {31'd0, st});
      chk("busy_addr", mem_addr, a & 32'hFFFF_FFFC);
      chk("busy_strb", {28'd0, mem_wstrb}, {28'd0, e_strb});
      if (st) chk("busy_wdata", mem_wdata, e_wdata);
      if (stall) stalls++;
    end
    mem_ack = 1'b1; mem_rdata = rword;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = $urandom;
    #1;
    chk("done_stall", {31'd0, stall}, 32'd0);
    chk("done_req", {31'd0, mem_req}, 32'd0);
    chk("done_lvalid", {31'd0, load_valid}, {31'd0, !st});
    if (!st) model_ld = e_ld;
    chk("done_ldata", load_data, model_ld);
    chk("stall_cycles", stalls, 2 + wt);
    @(posedge clk); #1;
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  initial begin
    n_total = 0; n_bad = 0; model_ld = 32'd0;
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; funct3 = 3'd0;
    addr = 32'd0; wdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_bits", {27'd0, mem_we, mem_wstrb}, 32'd0);
    chk("rst_ldata", load_data, 32'd0);
    chk("rst_flags", {28'd0, load_valid, stall, ld_misalign, st_misalign}, 32'd0);
    @(negedge clk); rst = 1'b0;

    // Directed cases
    do_access(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'd0, 32'h80FF_1234, 0);  // LB
    chk("lb_result", load_data, 32'hFFFF_FF80);
    do_access(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'd0, 0);  // SH
    do_access(1'b1, 1'b0, 3'b010, 32'h0000_0301, 32'd0, 32'd0, 0);          // LW misaligned
    do_access(1'b0, 1'b1, 3'b010, 32'h0000_0302, 32'd0, 32'd0, 0);          // SW misaligned
    do_access(1'b1, 1'b0, 3'b101, 32'h0000_0400, 32'd0, 32'h1234_F00D, 3);  // LHU slow ack
    chk("lhu_result", load_data, 32'h0000_F00D);
    do_access(1'b1, 1'b1, 3'b000, 32'h0000_0501, 32'h0000_0077, 32'd0, 1);  // SB, both enables

    // Reset while BUSY, then a stray ack after release
    @(negedge clk);
    rd_en = 1'b1; funct3 = 3'b010; addr = 32'h0000_0600;
    @(negedge clk); #1;
    chk("rb_req_on", {31'd0, mem_req}, 32'd1);
    rst = 1'b1; rd_en = 1'b0;
    #1;
    chk("rb_req_drop", {31'd0, mem_req}, 32'd0);
    chk("rb_stall", {31'd0, stall}, 32'd0);
    model_ld = 32'd0;
    chk("rb_ldata", load_data, model_ld);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk); mem_ack = 1'b0;
    #1;
    chk("rb_late_ack", {30'd0, mem_req, load_valid}, 32'd0);
    chk("rb_ldata2", load_data, model_ld);

    // Randomized accesses
    for (int n = 0; n < 60; n++) begin
      logic        r;
      logic        w;
      logic [2:0]  f;
      logic [31:0] a;
      r = 1'($urandom_range(0, 1));
      w = r ? 1'($urandom_range(0, 1)) : 1'b1;
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a = a & 32'hFFFF_FFFC;
      do_access(r, w, f, a, $urandom, $urandom, int'($urandom_range(0, 3)));
    end

    @(negedge clk); #1;
    chk("final_lvalid", {31'd0, load_valid}, 32'd0);
    chk("final_ldata", load_data, model_ld);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
